// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: widths, FSM encoding,
// inverse S-box and GF(2^8) multiply helpers.
package aes_pkg;

  localparam int TEXT_WIDTH      = 128;
  localparam int BYTE_WIDTH      = 8;
  localparam int FOUR_BYTE_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entry 0x00 sits in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sb(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [TEXT_WIDTH-1:0] state,
  input  logic [TEXT_WIDTH-1:0] round_key,
  input  logic                  last,
  output logic [TEXT_WIDTH-1:0] nxt
);

  logic [BYTE_WIDTH-1:0] a [16];
  logic [BYTE_WIDTH-1:0] b [16];
  logic [FOUR_BYTE_WIDTH-1:0] col;

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
            gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
            gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
            gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
  endfunction

  always_comb begin
    nxt = '0;
    col = '0;
    for (int k = 0; k < 16; k++)
      a[k] = state[127-8*k -: 8];
    // s(r,c) takes s(r,c-r) on the inverse row rotation
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = inv_sb(a[4*((c-r+4)%4)+r])
                 ^ round_key[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      col = {b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]};
      nxt[127-32*c -: 32] = last ? col : inv_mix(col);
    end
  end

endmodule

// File: rtl/aes_dec_core.sv
// Iterative AES-128 decryption core, one round per clock.
// AES_DEC_CLR_OUT_EN: mask text_o to zero unless out_valid_o.
module aes_dec_core
  import aes_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [TEXT_WIDTH-1:0] key_i,
  input  logic [TEXT_WIDTH-1:0] key0_i,
  input  logic [TEXT_WIDTH-1:0] key1_i,
  input  logic [TEXT_WIDTH-1:0] key2_i,
  input  logic [TEXT_WIDTH-1:0] key3_i,
  input  logic [TEXT_WIDTH-1:0] key4_i,
  input  logic [TEXT_WIDTH-1:0] key5_i,
  input  logic [TEXT_WIDTH-1:0] key6_i,
  input  logic [TEXT_WIDTH-1:0] key7_i,
  input  logic [TEXT_WIDTH-1:0] key8_i,
  input  logic [TEXT_WIDTH-1:0] key9_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [TEXT_WIDTH-1:0] text_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [TEXT_WIDTH-1:0] text_o
);

  state_t                state, state_nxt;
  logic [TEXT_WIDTH-1:0] st, rkey, round_out;
  logic [3:0]            rnd;
  logic                  last, acc;

  assign last = (rnd == 4'd10);
  assign acc  = in_valid_i && in_ready_o;

  always_comb begin
    rkey = key9_i;
    case (rnd)
      4'd1:    rkey = key0_i;
      4'd2:    rkey = key1_i;
      4'd3:    rkey = key2_i;
      4'd4:    rkey = key3_i;
      4'd5:    rkey = key4_i;
      4'd6:    rkey = key5_i;
      4'd7:    rkey = key6_i;
      4'd8:    rkey = key7_i;
      4'd9:    rkey = key8_i;
      default: rkey = key9_i;
    endcase
  end

  aes_inv_round u_round (
    .state     (st),
    .round_key (rkey),
    .last      (last),
    .nxt       (round_out)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (acc) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        if (acc)              state_nxt = RUN;
        else if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st  <= '0;
      rnd <= '0;
    end else if (acc) begin
      st  <= text_i ^ key_i;
      rnd <= 4'd1;
    end else if (state == RUN) begin
      st <= round_out;
      if (!last) rnd <= rnd + 4'd1;
    end
  end

  always_comb begin
    in_ready_o  = (state == IDLE) ||
                  (state == DONE && out_ready_i);
    out_valid_o = (state == DONE);
`ifdef AES_DEC_CLR_OUT_EN
    text_o = out_valid_o ? st : '0;
`else
    text_o = st;
`endif
  end

endmodule

// File: tb/tb_aes_dec_core.sv
// Scoreboard bench for aes_dec_core using FIPS-197 vectors.
module tb_aes_dec_core;
  import aes_pkg::*;

  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] text_in, text_out, exp_pt;
  logic [127:0] rk [11];
  logic [7:0]   sbox [256];

  int           n_chk = 0, n_pass = 0, cyc = 0;
  logic         ov_q = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_dec_core dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .key_i       (rk[10]),
    .key0_i      (rk[9]),
    .key1_i      (rk[8]),
    .key2_i      (rk[7]),
    .key3_i      (rk[6]),
    .key4_i      (rk[5]),
    .key5_i      (rk[4]),
    .key6_i      (rk[3]),
    .key7_i      (rk[2]),
    .key8_i      (rk[1]),
    .key9_i      (rk[0]),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .text_i      (text_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .text_o      (text_out)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]],
             sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [127:0] ct, input logic [127:0] pt,
                      input logic [127:0] key);
    bit ok = 0;
    expand(key);
    text_in  = ct;
    exp_pt   = pt;
    in_valid = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", 128'(ok), 128'd1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk("out_timeout", 128'(ok), 128'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_q) begin
        if (acc_q.size() > 0)
          chk("latency", 128'(cyc - acc_q.pop_front()), 128'd10);
        else
          chk("spurious_valid", 128'd1, 128'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0)
          chk("plaintext", text_out, exp_q.pop_front());
        else
          chk("unexpected_out", text_out, 128'hx);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_pt);
        acc_q.push_back(cyc + 1);
      end
      ov_q = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 0;
    in_valid  = 0;
    out_ready = 1;
    text_in   = '0;
    exp_pt    = '0;
    for (int i = 0; i < 256; i++) sbox[inv_sb(8'(i))] = 8'(i);
    expand(KEY_C);
    #23;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_text", text_out, 128'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // C.1 single block
    send(CT_C, PT_C, KEY_C);
    chk("run_in_ready", 128'(in_ready), 128'd0);
`ifdef AES_DEC_CLR_OUT_EN
    for (int i = 0; i < 9; i++) begin
      chk("run_text_clr", text_out, 128'd0);
      @(posedge clk); #1;
    end
`else
    chk("first_ark", text_out, CT_C ^ rk[10]);
`endif
    wait_out();
    @(posedge clk); #1;
    chk("idle_after_c1", 128'(in_ready && !out_valid), 128'd1);

    // back-to-back: second accept in DONE of the first
    send(CT_C, PT_C, KEY_C);
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_done", 128'(out_valid), 128'd1);
    send(CT_B, PT_B, KEY_B);
    chk("b2b_run_valid", 128'(out_valid), 128'd0);
    chk("b2b_run_ready", 128'(in_ready), 128'd0);
    wait_out();
    @(posedge clk); #1;

    // backpressure in DONE
    out_ready = 0;
    send(CT_B, PT_B, KEY_B);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      chk("bp_text", text_out, PT_B);
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_idle_valid", 128'(out_valid), 128'd0);
    chk("bp_idle_ready", 128'(in_ready), 128'd1);

    // reset mid-block at round 5
    send(CT_C, PT_C, KEY_C);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_text", text_out, 128'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    send(CT_C, PT_C, KEY_C);
    wait_out();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
